pulpino_byte_word_reader: RTL and testbench
===========================================

// Module: pulpino_byte_word_reader
// PURPOSE
//  Downstream partner of the upstream word-to-byte writer. Consumes 8-bit bytes over the
//  byte/word flicker handshake, reassembles each group of 4 bytes (LSB first) into a 32-bit
//  word, and acknowledges it. Completed words go out on a 1-entry valid/ready holding register.
//  Protocol violations and stalls are reported on sticky error flags.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles spent waiting on the writer mid-word; 0 disables timeout
// PORTS
//  clk                     in   1   sole clock, rising edge
//  rst                     in   1   synchronous reset, active-high
//  in_data                 in   8   byte from writer
//  did_byte_write_flicker  in   1   writer byte level; new byte when != did_byte_read_flicker
//  did_word_write_flicker  in   1   writer word-complete level
//  did_byte_read_flicker   out  1   byte ack level, registered
//  did_word_read_flicker   out  1   word ack level, registered
//  enable                  out  1   permits writer to start a word, registered
//  word_data               out  32  assembled word {b3,b2,b1,b0}
//  word_valid              out  1   word_data valid
//  word_ready              in   1   downstream accepts when word_valid & word_ready
//  proto_error             out  1   sticky: word flicker high before 4 bytes captured
//  timeout_error           out  1   sticky: writer stalled TIMEOUT_CYCLES
//  err_clear               in   1   clears both error flags
// BEHAVIOUR
//  - All outputs registered, no comb path in->out (writer outputs are comb on our acks).
//  - Reset: all outputs 0, state IDLE, byte count 0, timeout counter 0. Mid-word reset drops
//    the partial word.
//  - States: IDLE, BYTES, WORD_ACK, WAIT_LOW.
//  - IDLE: enable=~(proto_error|timeout_error). On byte flicker != byte ack: capture, go BYTES.
//  - Capture rule: when did_byte_write_flicker != did_byte_read_flicker, store in_data at lane
//    cnt (cnt 0..3, lane cnt*8 +: 8), cnt++, and copy the write flicker into
//    did_byte_read_flicker on the same edge. Exactly one capture per toggle.
//  - Byte flicker levels per word: 1,0,1,0. A fully acked word leaves did_byte_read_flicker=0.
//  - BYTES: after 4th capture (cnt wraps to 0), go WORD_ACK. did_word_write_flicker=1 while
//    cnt<4 and no capture pending -> set proto_error; force both ack flickers to 0, go IDLE.
//  - WORD_ACK: when did_word_write_flicker=1 and (!word_valid | word_ready): load word_data,
//    set word_valid=1, set did_word_read_flicker=1, go WAIT_LOW. If holding reg is full, stay
//    (backpressure; not counted toward timeout).
//  - Same-cycle pop and load allowed: new word overwrites, word_valid stays 1.
//  - WAIT_LOW: did_word_write_flicker=0 -> did_word_read_flicker=0, go IDLE (writer needs the
//    ack low before the next word).
//  - word_valid clears on word_valid & word_ready with no same-cycle load.
//  - Timeout: counter runs in BYTES/WORD_ACK/WAIT_LOW while the awaited event is absent.
//    Cleared on every capture or state change. At TIMEOUT_CYCLES: set timeout_error, zero both
//    ack flickers and cnt, go IDLE.
//  - Errors: sticky until err_clear or rst. err_clear and a new error in the same cycle ->
//    error wins. enable=0 while any error is set.
//  - Latency: byte ack 1 cycle after the flicker toggle is seen. Word valid 1 cycle after
//    did_word_write_flicker=1 is seen in WORD_ACK.
// TESTING
//  1. Writer model sends 0xDEADBEEF, word_ready=1 -> one word_valid pulse with 0xDEADBEEF;
//     both ack flickers end at 0; enable=1.
//  2. word_ready=0, send 0x11223344 then 0x55667788 -> second word stalls in WORD_ACK
//     (did_word_read_flicker=0). Raise ready -> words emerge in order; no timeout_error.
//  3. Raise did_word_write_flicker after 2 bytes -> proto_error=1, state IDLE, acks 0,
//     enable=0. err_clear -> enable=1; next word 0x0A0B0C0D OK.
//  4. TIMEOUT_CYCLES=16, writer freezes after byte 1 -> timeout_error rises exactly 16 cycles
//     after the last capture; acks 0.
//  5. rst pulse after 3 bytes -> all outputs 0 next cycle; following word 0xCAFEF00D
//     assembled correctly.
//  6. Back-to-back 8 random words with ready toggling randomly -> output order and data
//     match; no errors.

Source files
------------

// File: rtl/pulpino_byte_word_reader.sv
// Byte-to-word reader: collects four bytes from the flicker handshake, LSB first,
// and hands each assembled word to a one-entry valid/ready holding register.
module pulpino_byte_word_reader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        did_byte_write_flicker,
    input  logic        did_word_write_flicker,
    output logic        did_byte_read_flicker,
    output logic        did_word_read_flicker,
    output logic        enable,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        proto_error,
    output logic        timeout_error,
    input  logic        err_clear
);

    typedef enum logic [1:0] {StIdle, StBytes, StWordAck, StWaitLow} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] data_q, data_d;
    logic        byte_ack_q, byte_ack_d;
    logic        word_ack_q, word_ack_d;
    logic        valid_q, valid_d;
    logic        enable_q, enable_d;
    logic        perr_q, perr_d;
    logic        terr_q, terr_d;

    logic pending, capture, waiting, perr_set, terr_set;

    assign pending = did_byte_write_flicker != byte_ack_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        tcnt_d     = tcnt_q;
        data_d     = data_q;
        byte_ack_d = byte_ack_q;
        word_ack_d = word_ack_q;
        valid_d    = valid_q;
        capture    = 1'b0;
        waiting    = 1'b0;
        perr_set   = 1'b0;
        terr_set   = 1'b0;

        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (pending) begin
                    capture = 1'b1;
                    state_d = StBytes;
                end
            end
            StBytes: begin
                if (pending) begin
                    capture = 1'b1;
                    if (cnt_q == 2'd3) begin
                        state_d = StWordAck;
                    end
                end else if (did_word_write_flicker) begin
                    perr_set   = 1'b1;
                    byte_ack_d = 1'b0;
                    word_ack_d = 1'b0;
                    cnt_d      = 2'd0;
                    state_d    = StIdle;
                end else begin
                    waiting = 1'b1;
                end
            end
            StWordAck: begin
                // A full holding register is backpressure, not a stalled writer.
                if (did_word_write_flicker) begin
                    if (!valid_q || word_ready) begin
                        data_d     = buf_q;
                        valid_d    = 1'b1;
                        word_ack_d = 1'b1;
                        state_d    = StWaitLow;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            StWaitLow: begin
                if (!did_word_write_flicker) begin
                    word_ack_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    waiting = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            buf_d[{cnt_q, 3'b000} +: 8] = in_data;
            cnt_d      = cnt_q + 2'd1;
            byte_ack_d = did_byte_write_flicker;
        end

        if (capture || state_d != state_q) begin
            tcnt_d = 32'd0;
        end else if (waiting) begin
            if (TIMEOUT_CYCLES != 0 && tcnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                terr_set   = 1'b1;
                byte_ack_d = 1'b0;
                word_ack_d = 1'b0;
                cnt_d      = 2'd0;
                tcnt_d     = 32'd0;
                state_d    = StIdle;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end

        perr_d   = perr_set | (perr_q & ~err_clear);
        terr_d   = terr_set | (terr_q & ~err_clear);
        enable_d = (state_d == StIdle) & ~(perr_d | terr_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            buf_q      <= 32'd0;
            tcnt_q     <= 32'd0;
            data_q     <= 32'd0;
            byte_ack_q <= 1'b0;
            word_ack_q <= 1'b0;
            valid_q    <= 1'b0;
            enable_q   <= 1'b0;
            perr_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            tcnt_q     <= tcnt_d;
            data_q     <= data_d;
            byte_ack_q <= byte_ack_d;
            word_ack_q <= word_ack_d;
            valid_q    <= valid_d;
            enable_q   <= enable_d;
            perr_q     <= perr_d;
            terr_q     <= terr_d;
        end
    end

    assign did_byte_read_flicker = byte_ack_q;
    assign did_word_read_flicker = word_ack_q;
    assign enable                = enable_q;
    assign word_data             = data_q;
    assign word_valid            = valid_q;
    assign proto_error           = perr_q;
    assign timeout_error         = terr_q;

endmodule

// File: tb/tb_pulpino_byte_word_reader.sv
// Bench for pulpino_byte_word_reader: a behavioural writer drives the flicker handshake and
// a queue of expected words is compared against every accepted output word.
module tb_pulpino_byte_word_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        bw, ww;
    logic        bra, wra;
    logic        enable;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        proto_error, timeout_error;
    logic        err_clear;

    int          checks = 0;
    int          errors = 0;
    int          xfers  = 0;
    int          pushed = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] exp_q[$];

    pulpino_byte_word_reader #(.TIMEOUT_CYCLES(16)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_data                (in_data),
        .did_byte_write_flicker (bw),
        .did_word_write_flicker (ww),
        .did_byte_read_flicker  (bra),
        .did_word_read_flicker  (wra),
        .enable                 (enable),
        .word_data              (word_data),
        .word_valid             (word_valid),
        .word_ready             (word_ready),
        .proto_error            (proto_error),
        .timeout_error          (timeout_error),
        .err_clear              (err_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: a transfer happens on the posedge following a sample with valid & ready.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && word_valid === 1'b1 && word_ready === 1'b1) begin
                xfers++;
                if (exp_q.size() == 0) chk("spurious_word", 32'(exp_q.size()), 32'd1);
                else chk("word_data", word_data, exp_q.pop_front());
            end
        end
    end

    // Random ready changes 2 time units after posedge, so it is stable across sampling.
    initial begin
        forever begin
            @(posedge clk);
            if (rand_ready) begin
                #2;
                word_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic wait_enable();
        int n = 0;
        while (enable !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("enable_wait", enable, 1);
    endtask

    task automatic wait_wra(input logic lvl, input int limit, input string tag);
        int n = 0;
        while (wra !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, wra, lvl);
    endtask

    // Writer model: byte i of w goes out with flicker level 1,0,1,0.
    task automatic send_bytes(input logic [31:0] w, input int nbytes, input int gap_max);
        wait_enable();
        for (int i = 0; i < nbytes; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            in_data = w[i*8 +: 8];
            bw      = (i % 2 == 0);
            @(negedge clk);
            chk("byte_ack", bra, bw);
        end
        if (nbytes == 4) begin
            exp_q.push_back(w);
            pushed++;
        end
    endtask

    task automatic finish_word();
        ww = 1'b1;
        @(negedge clk);
        wait_wra(1'b1, 300, "word_ack_hi");
        ww = 1'b0;
        @(negedge clk);
        wait_wra(1'b0, 4, "word_ack_lo");
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        send_bytes(w, 4, gap_max);
        finish_word();
    endtask

    initial begin
        int n;
        int x0;
        logic [31:0] w;
        rst = 1'b1; in_data = 8'h00; bw = 1'b0; ww = 1'b0;
        word_ready = 1'b0; err_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", word_valid, 0);
        chk("rst_enable", enable, 0);
        chk("rst_bra", bra, 0);
        chk("rst_wra", wra, 0);
        chk("rst_errs", {proto_error, timeout_error}, 0);
        rst = 1'b0;

        // 1: single word, ready high
        word_ready = 1'b1;
        x0 = xfers;
        send_word(32'hDEADBEEF, 0);
        repeat (3) @(negedge clk);
        chk("t1_xfers", xfers - x0, 1);
        chk("t1_bra", bra, 0);
        chk("t1_wra", wra, 0);
        chk("t1_enable", enable, 1);

        // 2: backpressure holds second word in word-ack phase without timing out
        word_ready = 1'b0;
        send_word(32'h11223344, 0);
        send_bytes(32'h55667788, 4, 0);
        ww = 1'b1;
        repeat (20) @(negedge clk);
        chk("t2_wra_stall", wra, 0);
        chk("t2_valid", word_valid, 1);
        chk("t2_hold_data", word_data, 32'h11223344);
        chk("t2_no_timeout", timeout_error, 0);
        word_ready = 1'b1;
        wait_wra(1'b1, 10, "t2_wra_hi");
        ww = 1'b0;
        @(negedge clk);
        wait_wra(1'b0, 4, "t2_wra_lo");
        repeat (3) @(negedge clk);
        chk("t2_drained", 32'(exp_q.size()), 0);
        chk("t2_no_timeout_end", timeout_error, 0);

        // 3: premature word flicker after two bytes
        send_bytes(32'h99999999, 2, 0);
        ww = 1'b1;
        @(negedge clk);
        chk("t3_proto", proto_error, 1);
        chk("t3_bra", bra, 0);
        chk("t3_wra", wra, 0);
        chk("t3_enable", enable, 0);
        ww = 1'b0;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        chk("t3_cleared", proto_error, 0);
        chk("t3_enable_back", enable, 1);
        send_word(32'h0A0B0C0D, 0);

        // 4: writer freezes after first byte
        send_bytes(32'h000000A5, 1, 0);
        n = 0;
        while (timeout_error !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bw = 1'b0;
        chk("t4_timeout", timeout_error, 1);
        chk("t4_cycles", n, 16);
        chk("t4_bra", bra, 0);
        chk("t4_wra", wra, 0);
        chk("t4_enable", enable, 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        chk("t4_cleared", timeout_error, 0);

        // 5: reset mid-word drops the partial word
        send_bytes(32'h00776655, 3, 0);
        rst = 1'b1;
        bw  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_bra", bra, 0);
        chk("t5_data", word_data, 0);
        chk("t5_valid", word_valid, 0);
        chk("t5_enable", enable, 0);
        send_word(32'hCAFEF00D, 0);
        repeat (3) @(negedge clk);
        chk("t5_drained", 32'(exp_q.size()), 0);

        // 6: random back-to-back words with random ready
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            send_word(w, 3);
        end
        @(negedge clk);
        rand_ready = 1'b0;
        word_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("t6_drained", 32'(exp_q.size()), 0);
        chk("t6_errs", {proto_error, timeout_error}, 0);
        chk("total_xfers", xfers, pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
